sr_ff_bank: RTL
===============

// Module: sr_ff_bank
// PURPOSE
//  Bank of WIDTH independent clocked set/reset flip-flops; successor to the single-bit SR latch.
//  Edge-triggered and glitch-free; per-channel S/R inputs; the S=R=1 condition is resolved by a
//  build-time MODE policy instead of producing Q=Qbar. Detected illegal S=R=1 requests are
//  flagged and counted. Used as the status/flag register bank for control logic.
// PARAMETERS
//  WIDTH      8    number of flip-flop channels (>=1)
//  MODE       0    S=R=1 policy: 0=hold+flag, 1=set-dominant+flag, 2=reset-dominant+flag, 3=toggle (JK, legal)
//  RESET_VAL  0    WIDTH-bit reset value of q
//  CNT_W      8    width of the error event counter (>=2)
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       synchronous active-high reset
//  en        in   1       update enable; 0 = all channels hold
//  s         in   WIDTH   per-channel set request
//  r         in   WIDTH   per-channel reset request
//  clr_err   in   1       clear err_count and err_sticky
//  q         out  WIDTH   registered state
//  qbar      out  WIDTH   always ~q (derived, never equal to q)
//  invalid   out  WIDTH   registered 1-cycle flag: channel saw S=R=1 with en=1 (MODE 0-2)
//  err_count out  CNT_W   saturating count of cycles with any invalid request
//  err_sticky out 1       set on first invalid request, held until clr_err/rst
// BEHAVIOUR
//  - All state updates on rising clk; latency 1 cycle from s/r/en to q, invalid, err_*.
//  - rst=1: q=RESET_VAL, qbar=~RESET_VAL, invalid=0, err_count=0, err_sticky=0.
//    rst overrides en, s, r, clr_err; reset asserted mid-sequence discards that cycle's requests.
//  - en=0: q holds, invalid=0, err_count/err_sticky unchanged by s/r (clr_err still acts).
//  - en=1, per channel i:  s=0 r=0 -> hold;  s=1 r=0 -> q=1;  s=0 r=1 -> q=0;
//    s=1 r=1 -> MODE0 hold, MODE1 q=1, MODE2 q=0, MODE3 q=~q.
//  - invalid[i] = en & s[i] & r[i] for MODE 0-2, registered; MODE 3: invalid tied 0.
//  - Event cycle = any bit of next invalid set. Counts one per cycle, not per channel.
//  - err_count: +1 per event cycle, saturates at 2^CNT_W-1 (no wrap).
//  - err_sticky: set on event cycle.
//  - clr_err=1 with no event: err_count=0, err_sticky=0.
//    clr_err=1 with event same cycle: err_count=1, err_sticky=1 (event not lost).
//  - Channels fully independent; no cross-channel priority.
//  - No latches, no combinational path from inputs to outputs; qbar is ~q of the register.
// TESTING (WIDTH=4, RESET_VAL=4'b0000, CNT_W=4 unless noted)
//  1. rst=1 one cycle, then en=1 s=4'b0101 r=0 -> next edge q=4'b0101, qbar=4'b1010, invalid=0.
//  2. From q=4'b0101: s=0 r=4'b0001 -> q=4'b0100; then en=0 s=4'b1111 -> q stays 4'b0100.
//  3. MODE0, q=4'b0100, s=r=4'b0110 -> q=4'b0100, invalid=4'b0110 for one cycle,
//     err_count=1, err_sticky=1; MODE1 same stim -> q=4'b0110; MODE2 -> q=4'b0000.
//  4. MODE3, q=4'b0100, s=r=4'b1111 two cycles -> q=4'b1011 then 4'b0100, invalid=0, err_count=0.
//  5. MODE0: 20 consecutive cycles s=r=4'b0001 -> err_count saturates at 15; clr_err with
//     same stim -> err_count=1, err_sticky=1; clr_err with s=r=0 -> err_count=0, sticky=0.
//  6. rst asserted in same cycle as s=4'b1111, clr_err=1 -> q=RESET_VAL, all flags/counter 0.

Source files
------------

// File: rtl/sr_ff_bank_if.sv
// Request/status bundle for sr_ff_bank: set/reset requests in, flip-flop state and error flags out.
interface sr_ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] invalid;
    logic [CNT_W-1:0] err_count;
    logic             err_sticky;

    modport master (
        output en, s, r, clr_err,
        input  q, qbar, invalid, err_count, err_sticky
    );

    modport slave (
        input  en, s, r, clr_err,
        output q, qbar, invalid, err_count, err_sticky
    );
endinterface

// File: rtl/sr_ff_bank.sv
// Bank of independent clocked set/reset flip-flops with a build-time S=R=1 policy
// and a saturating, clearable count of illegal simultaneous set/reset requests.
module sr_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter int               MODE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 8
) (
    input logic         clk,
    input logic         rst,
    sr_ff_bank_if.slave bus
);
    localparam int MODE_SET    = 1;
    localparam int MODE_RESET  = 2;
    localparam int MODE_TOGGLE = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] invalid_r;
    logic [CNT_W-1:0] err_count_r;
    logic             err_sticky_r;

    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] invalid_next_s;
    logic             event_s;
    logic [CNT_W-1:0] err_count_next_s;
    logic             err_sticky_next_s;

    // Per-channel next state, including the S=R=1 resolution policy.
    always_comb begin
        q_next_s = q_r;
        if (bus.en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({bus.s[i], bus.r[i]})
                    2'b10: q_next_s[i] = 1'b1;
                    2'b01: q_next_s[i] = 1'b0;
                    2'b11: begin
                        if (MODE == MODE_SET) begin
                            q_next_s[i] = 1'b1;
                        end else if (MODE == MODE_RESET) begin
                            q_next_s[i] = 1'b0;
                        end else if (MODE == MODE_TOGGLE) begin
                            q_next_s[i] = ~q_r[i];
                        end else begin
                            q_next_s[i] = q_r[i];
                        end
                    end
                    default: q_next_s[i] = q_r[i];
                endcase
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Illegal-request detection; in toggle mode S=R=1 is a legal JK toggle.
    always_comb begin
        invalid_next_s = {WIDTH{1'b0}};
        if (bus.en && (MODE != MODE_TOGGLE)) begin
            invalid_next_s = bus.s & bus.r;
        end else begin
            invalid_next_s = {WIDTH{1'b0}};
        end
        event_s = |invalid_next_s;
    end

    // Error bookkeeping; an event coinciding with clr_err is recorded, not lost.
    always_comb begin
        err_count_next_s  = err_count_r;
        err_sticky_next_s = err_sticky_r;
        if (bus.clr_err) begin
            err_count_next_s  = event_s ? CNT_ONE : {CNT_W{1'b0}};
            err_sticky_next_s = event_s;
        end else if (event_s) begin
            err_count_next_s  = (err_count_r == CNT_MAX) ? CNT_MAX : err_count_r + CNT_ONE;
            err_sticky_next_s = 1'b1;
        end else begin
            err_count_next_s  = err_count_r;
            err_sticky_next_s = err_sticky_r;
        end
    end

    // State and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r          <= RESET_VAL;
            invalid_r    <= {WIDTH{1'b0}};
            err_count_r  <= {CNT_W{1'b0}};
            err_sticky_r <= 1'b0;
        end else begin
            q_r          <= q_next_s;
            invalid_r    <= invalid_next_s;
            err_count_r  <= err_count_next_s;
            err_sticky_r <= err_sticky_next_s;
        end
    end

    assign bus.q          = q_r;
    assign bus.qbar       = ~q_r;
    assign bus.invalid    = invalid_r;
    assign bus.err_count  = err_count_r;
    assign bus.err_sticky = err_sticky_r;
endmodule
